// File: rtl/fp_div_client.sv
// fp_div_client: initiator-side driver for an stb/ack floating-point divider
// Ports:
//   aclk, rstn              clock, asynchronous active-low reset
//   req_*                   valid/ready job input: dividend, divisor, tag
//   rsp_*                   valid/ready result output: quotient, tag, class flags {timeout,zero,inf,nan}
//   div_a*, div_b*          operand channels to the divider (stb/ack, both complete on the same edge)
//   div_ans*                result channel from the divider (stb/ack)
//   timeout_err             sticky watchdog-abort indicator
//   done_count              responses delivered, wraps
module fp_div_client #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic             aclk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [3:0]       rsp_flags,
    output logic [31:0]      div_a,
    output logic             div_a_stb,
    input  logic             div_a_ack,
    output logic [31:0]      div_b,
    output logic             div_b_stb,
    input  logic             div_b_ack,
    input  logic [31:0]      div_ans,
    input  logic             div_ans_stb,
    output logic             div_ans_ack,
    output logic             timeout_err,
    output logic [CNT_W-1:0] done_count
);
    localparam int WD_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ANS, HOLD_RSP, HOLD_DRAIN} state_t;
    state_t state, state_d;
    logic [WD_W-1:0] wd, wd_d, wd_inc;
    logic drain_ok, drain_ok_d, wd_hit, rsp_hs;
    logic req_ready_d, rsp_valid_d, div_a_stb_d, div_b_stb_d, div_ans_ack_d, timeout_err_d;
    logic [31:0] rsp_data_d, div_a_d, div_b_d;
    logic [TAG_W-1:0] rsp_tag_d;
    logic [3:0] rsp_flags_d;
    logic [CNT_W-1:0] done_count_d;

    // {timeout, zero, inf, nan}; classes are mutually exclusive by construction
    function automatic logic [3:0] classify(input logic [31:0] v);
        return {1'b0, ~|v[30:0], (&v[30:23]) & ~|v[22:0], (&v[30:23]) & |v[22:0]};
    endfunction

    always_comb begin
        state_d       = state;
        wd_d          = wd;
        drain_ok_d    = drain_ok;
        req_ready_d   = req_ready;
        rsp_valid_d   = rsp_valid;
        rsp_data_d    = rsp_data;
        rsp_tag_d     = rsp_tag;
        rsp_flags_d   = rsp_flags;
        div_a_d       = div_a;
        div_b_d       = div_b;
        div_a_stb_d   = div_a_stb;
        div_b_stb_d   = div_b_stb;
        div_ans_ack_d = div_ans_ack;
        timeout_err_d = timeout_err;
        done_count_d  = done_count;
        wd_inc        = wd + 1'b1;
        wd_hit        = (TIMEOUT != 0) && (wd_inc == WD_LIM);
        rsp_hs        = rsp_valid && rsp_ready;
        case (state)
            IDLE: if (req_valid) begin
                div_a_d     = req_a;
                div_b_d     = req_b;
                rsp_tag_d   = req_tag;
                req_ready_d = 1'b0;
                div_a_stb_d = 1'b1;
                div_b_stb_d = 1'b1;
                state_d     = ISSUE;
            end
            // a lone ack on one channel is ignored so both operands always move together
            ISSUE: if (div_a_ack && div_b_ack) begin
                div_a_stb_d   = 1'b0;
                div_b_stb_d   = 1'b0;
                div_ans_ack_d = 1'b1;
                wd_d          = '0;
                state_d       = WAIT_ANS;
            end
            WAIT_ANS: if (div_ans_stb) begin
                rsp_data_d    = div_ans;
                rsp_flags_d   = classify(div_ans);
                rsp_valid_d   = 1'b1;
                div_ans_ack_d = 1'b0;
                state_d       = HOLD_RSP;
            end else if (TIMEOUT != 0) begin
                wd_d = wd_inc;
                if (wd_hit) begin
                    rsp_data_d    = 32'hFFC0_0000;
                    rsp_flags_d   = 4'b1000;
                    rsp_valid_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    wd_d          = '0;
                    drain_ok_d    = 1'b0;
                    state_d       = HOLD_DRAIN;
                end
            end
            HOLD_RSP: if (rsp_hs) begin
                rsp_valid_d  = 1'b0;
                done_count_d = done_count + 1'b1;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            // the abandoned divider result is swallowed here so it can never leak into a later job
            HOLD_DRAIN: begin
                if (rsp_hs) begin
                    rsp_valid_d  = 1'b0;
                    done_count_d = done_count + 1'b1;
                end
                if (!drain_ok) begin
                    wd_d = wd_inc;
                    drain_ok_d = div_ans_stb || wd_hit;
                end
                if ((rsp_hs || !rsp_valid) && (drain_ok || div_ans_stb || wd_hit)) begin
                    div_ans_ack_d = 1'b0;
                    req_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            wd          <= '0;
            drain_ok    <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
            rsp_flags   <= '0;
            div_a       <= '0;
            div_b       <= '0;
            div_a_stb   <= 1'b0;
            div_b_stb   <= 1'b0;
            div_ans_ack <= 1'b0;
            timeout_err <= 1'b0;
            done_count  <= '0;
        end else begin
            state       <= state_d;
            wd          <= wd_d;
            drain_ok    <= drain_ok_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_tag     <= rsp_tag_d;
            rsp_flags   <= rsp_flags_d;
            div_a       <= div_a_d;
            div_b       <= div_b_d;
            div_a_stb   <= div_a_stb_d;
            div_b_stb   <= div_b_stb_d;
            div_ans_ack <= div_ans_ack_d;
            timeout_err <= timeout_err_d;
            done_count  <= done_count_d;
        end
    end
endmodule

// File: tb/tb_fp_div_client.sv
// tb_fp_div_client: directed self-checking bench for fp_div_client with a hand-driven divider stub
module tb_fp_div_client;
    logic        aclk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_a = '0, req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag, rsp_flags;
    logic [31:0] div_a, div_b, div_ans = '0;
    logic        div_a_stb, div_b_stb, div_a_ack = 1'b0, div_b_ack = 1'b0;
    logic        div_ans_stb = 1'b0, div_ans_ack, timeout_err;
    logic [15:0] done_count;
    int n_cmp = 0, n_fail = 0, xfer_cnt = 0, exp_done = 0, x0;

    fp_div_client #(.TAG_W(4), .TIMEOUT(16), .CNT_W(16)) dut (
        .aclk(aclk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
        .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
        .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
        .div_ans(div_ans), .div_ans_stb(div_ans_stb), .div_ans_ack(div_ans_ack),
        .timeout_err(timeout_err), .done_count(done_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (div_a_stb && div_a_ack && div_b_stb && div_b_ack) xfer_cnt <= xfer_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        chk("issue_stb_ready", {div_a_stb, div_b_stb, req_ready}, 3'b110);
        chk("issue_a", div_a, a);
        chk("issue_b", div_b, b);
    endtask

    task automatic ack_ops;
        div_a_ack = 1'b1; div_b_ack = 1'b1;
        tick;
        div_a_ack = 1'b0; div_b_ack = 1'b0;
        chk("xfer_stb_ack", {div_a_stb, div_b_stb, div_ans_ack}, 3'b001);
    endtask

    task automatic answer(input logic [31:0] ans, input logic [3:0] tag, input logic [3:0] flags);
        div_ans = ans; div_ans_stb = 1'b1;
        tick;
        div_ans_stb = 1'b0;
        chk("rsp_valid_ready_ack", {rsp_valid, req_ready, div_ans_ack}, 3'b100);
        chk("rsp_data", rsp_data, ans);
        chk("rsp_tag", rsp_tag, tag);
        chk("rsp_flags", rsp_flags, flags);
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        exp_done++;
        chk("consume_valid", rsp_valid, 1'b0);
        chk("done_count", done_count, exp_done);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                           input logic [31:0] ans, input logic [3:0] flags);
        start_job(a, b, tag);
        ack_ops;
        answer(ans, tag, flags);
        consume;
        chk("back_to_idle", req_ready, 1'b1);
    endtask

    initial begin
        #2 rstn = 1'b0;
        tick;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_ctrl", {rsp_valid, div_a_stb, div_b_stb, div_ans_ack, timeout_err}, 5'b0);
        chk("rst_data", {rsp_data, div_a}, 64'h0);
        chk("rst_misc", {div_b, rsp_tag, rsp_flags, done_count}, 64'h0);
        rstn = 1'b1;
        tick;
        // 6.0 / 2.0 = 3.0
        run_job(32'h40C0_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 4'b0000);
        // 1/0 -> inf, 0/0 -> NaN
        run_job(32'h3F80_0000, 32'h0000_0000, 4'd1, 32'h7F80_0000, 4'b0010);
        run_job(32'h0000_0000, 32'h0000_0000, 4'd2, 32'hFFC0_0000, 4'b0001);
        // zero result class
        run_job(32'h0000_0000, 32'h4000_0000, 4'd3, 32'h0000_0000, 4'b0100);
        exp_done = exp_done;
        // back-pressured response with a second job waiting
        start_job(32'h4120_0000, 32'h4000_0000, 4'd7);
        ack_ops;
        answer(32'h40A0_0000, 4'd7, 4'b0000);
        req_a = 32'h4040_0000; req_b = 32'h4000_0000; req_tag = 4'd8; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_data", rsp_data, 32'h40A0_0000);
            chk("hold_tag", rsp_tag, 4'd7);
            chk("hold_busy", {req_ready, div_a_stb}, 2'b00);
        end
        consume;
        chk("second_ready", req_ready, 1'b1);
        tick;
        req_valid = 1'b0;
        chk("second_issue", {div_a_stb, div_b_stb, req_ready}, 3'b110);
        chk("second_a", div_a, 32'h4040_0000);
        ack_ops;
        answer(32'h3FC0_0000, 4'd8, 4'b0000);
        consume;
        // only A acks for 3 cycles: no transfer until both ack on the same edge
        start_job(32'h4100_0000, 32'h4080_0000, 4'd9);
        x0 = xfer_cnt;
        div_a_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("partial_ack_stb", {div_a_stb, div_b_stb, div_ans_ack}, 3'b110);
        end
        chk("partial_ack_noxfer", xfer_cnt - x0, 0);
        div_b_ack = 1'b1;
        tick;
        div_a_ack = 1'b0; div_b_ack = 1'b0;
        chk("joint_ack_stb", {div_a_stb, div_b_stb, div_ans_ack}, 3'b001);
        tick;
        chk("one_xfer", xfer_cnt - x0, 1);
        answer(32'h4000_0000, 4'd9, 4'b0000);
        consume;
        // watchdog abort, late result absorbed inside the drain window
        start_job(32'h4000_0000, 32'h4000_0000, 4'd10);
        ack_ops;
        repeat (15) tick;
        chk("wd_not_yet", rsp_valid, 1'b0);
        tick;
        chk("wd_valid_ack_err", {rsp_valid, div_ans_ack, timeout_err, req_ready}, 4'b1110);
        chk("wd_data", rsp_data, 32'hFFC0_0000);
        chk("wd_flags", rsp_flags, 4'b1000);
        chk("wd_tag", rsp_tag, 4'd10);
        consume;
        chk("drain_wait", {req_ready, div_ans_ack}, 2'b01);
        repeat (6) tick;
        div_ans = 32'h3F80_0000; div_ans_stb = 1'b1;
        tick;
        div_ans_stb = 1'b0;
        chk("late_absorbed", {rsp_valid, req_ready, div_ans_ack}, 3'b010);
        chk("late_not_fwd", rsp_data, 32'hFFC0_0000);
        chk("late_count", done_count, exp_done);
        // watchdog abort, divider never answers: drain ends one TIMEOUT after abort
        start_job(32'h4000_0000, 32'h4000_0000, 4'd11);
        ack_ops;
        repeat (16) tick;
        chk("wd2_valid", rsp_valid, 1'b1);
        consume;
        repeat (14) tick;
        chk("drain2_busy", {req_ready, div_ans_ack}, 2'b01);
        tick;
        chk("drain2_done", {req_ready, div_ans_ack}, 2'b10);
        // asynchronous reset mid-job
        start_job(32'h40C0_0000, 32'h4040_0000, 4'd12);
        ack_ops;
        repeat (3) tick;
        #2 rstn = 1'b0;
        #1;
        chk("arst_ctrl", {req_ready, rsp_valid, div_ans_ack, timeout_err, div_a_stb}, 5'b10000);
        chk("arst_data", {rsp_data, div_a}, 64'h0);
        chk("arst_count", done_count, 16'd0);
        tick;
        rstn = 1'b1;
        exp_done = 0;
        repeat (3) tick;
        chk("arst_no_rsp", {rsp_valid, req_ready}, 2'b01);
        run_job(32'h40C0_0000, 32'h4040_0000, 4'd13, 32'h4000_0000, 4'b0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
